// File: rtl/ws2811_pkg.sv
// Shared types and constants for the WS2811 frame scheduler and its arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ws2811_pkg;

    localparam int LED_WIDTH = 24;
    localparam int MAX_LEDS  = 11;

    typedef logic [LED_WIDTH-1:0] grb_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/ws2811_rr_arbiter.sv
// Two-way round-robin arbiter for frame-buffer ownership.
// Latency: winner is combinational from req_i; the priority pointer moves one cycle after accept_i.
// Backpressure: none; the caller pulses accept_i only when it actually takes the winner.
//
// Ports:
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   req_i         : per-requester request bits
//   accept_i      : caller latched gnt_o this cycle, so advance the pointer
//   gnt_o         : one-hot winner (zero when nobody requests)
module ws2811_rr_arbiter
    import ws2811_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // ptr_q names the requester that wins a tie; it flips away from each accepted winner.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        // Winner 0 hands the tie to requester 1, and vice versa.
        if (accept_i && (|gnt_o)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ws2811_frame_scheduler.sv
// Owns the WS2811 frame buffer: arbitrates two writers, then kicks the strip controller on release or refresh.
// Latency: grant one cycle after req; strip_enable one cycle after the owner drops req or the refresh expires.
// Backpressure: requests outside IDLE are held off; each WAIT state is bounded by TIMEOUT_CYCLES.
//
// Ports:
//   clock_i, reset_ni      : system clock, asynchronous active-low reset
//   req_i / grant_o        : per-requester buffer request, one-hot ownership
//   wr_en_i/addr/data      : frame-buffer write port for the current owner
//   strip_busy_i           : strip controller is shifting a frame
//   strip_enable_o         : one-cycle start pulse to the strip controller
//   led_count_o            : constant NUM_LEDS
//   frame_out_o            : frame buffer, LED n at [24n+23:24n]
//   busy_o                 : FSM not in IDLE
//   frames_sent_o          : wrapping count of completed frames
//   timeout_err_o          : sticky, set when a WAIT state times out
module ws2811_frame_scheduler
    import ws2811_pkg::*;
#(
    parameter int NUM_LEDS       = 11,
    parameter int REFRESH_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES = 262143
) (
    input  logic                          clock_i,
    input  logic                          reset_ni,
    input  logic [1:0]                    req_i,
    output logic [1:0]                    grant_o,
    input  logic                          wr_en_i,
    input  logic [3:0]                    wr_addr_i,
    input  logic [LED_WIDTH-1:0]          wr_data_i,
    input  logic                          strip_busy_i,
    output logic                          strip_enable_o,
    output logic [7:0]                    led_count_o,
    output logic [NUM_LEDS*LED_WIDTH-1:0] frame_out_o,
    output logic                          busy_o,
    output logic [15:0]                   frames_sent_o,
    output logic                          timeout_err_o
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    NUM_LEDS_W   = 4'(NUM_LEDS);

    state_e        state_q,   state_d;
    logic [1:0]    grant_q,   grant_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic [15:0]   frames_q,  frames_d;
    logic          terr_q,    terr_d;

    logic [1:0]    arb_gnt;
    logic          arb_accept;
    logic          owner_req;
    logic          buf_we;

    grb_t          buf_q [NUM_LEDS];

    ws2811_rr_arbiter u_arb (
        .clk_i    (clock_i),
        .rst_ni   (reset_ni),
        .req_i    (req_i),
        .accept_i (arb_accept),
        .gnt_o    (arb_gnt)
    );

    assign owner_req = |(req_i & grant_q);
    assign buf_we    = (state_q == GRANT) && wr_en_i && (|grant_q) && (wr_addr_i < NUM_LEDS_W);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        refresh_d  = refresh_q;
        timer_d    = timer_q;
        frames_d   = frames_q;
        terr_d     = terr_q;
        arb_accept = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A request beats a refresh that expires in the same cycle.
                if (|req_i) begin
                    arb_accept = 1'b1;
                    grant_d    = arb_gnt;
                    state_d    = GRANT;
                end else if (refresh_q == REFRESH_LAST) begin
                    state_d = START;
                end else begin
                    refresh_d = refresh_q + RW'(1);
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    grant_d = 2'b00;
                    state_d = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (strip_busy_i) begin
                    timer_d = '0;
                    state_d = WAIT_DONE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    terr_d  = 1'b1;
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!strip_busy_i) begin
                    frames_d = frames_q + 16'd1;
                    timer_d  = '0;
                    state_d  = IDLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    terr_d  = 1'b1;
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase

        // Refresh period is measured from the start of the previous frame's idle gap.
        if (state_d == START) begin
            refresh_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            refresh_q <= '0;
            timer_q   <= '0;
            frames_q  <= 16'd0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            refresh_q <= refresh_d;
            timer_q   <= timer_d;
            frames_q  <= frames_d;
            terr_q    <= terr_d;
        end
    end

    // Writes only land in GRANT, so the buffer is frozen from START back to IDLE.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                buf_q[i] <= '0;
            end
        end else if (buf_we) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_addr_i == 4'(i)) begin
                    buf_q[i] <= wr_data_i;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_frame
        assign frame_out_o[g*LED_WIDTH +: LED_WIDTH] = buf_q[g];
    end

    assign grant_o        = grant_q;
    assign strip_enable_o = (state_q == START);
    assign busy_o         = (state_q != IDLE);
    assign led_count_o    = 8'(NUM_LEDS);
    assign frames_sent_o  = frames_q;
    assign timeout_err_o  = terr_q;

endmodule
